// File: rtl/pipe_exe_pkg.sv
// Shared encodings for the ID/EX register, execute stage and iterative mul/div unit.
package pipe_exe_pkg;

  typedef enum logic [3:0] {
    ALUC_ADD = 4'b0000,
    ALUC_SUB = 4'b0100,
    ALUC_AND = 4'b0001,
    ALUC_OR  = 4'b0101,
    ALUC_XOR = 4'b0010,
    ALUC_LUI = 4'b0110,
    ALUC_SLL = 4'b0011,
    ALUC_SRL = 4'b0111,
    ALUC_SRA = 4'b1111,
    ALUC_MUL = 4'b1011,
    ALUC_DIV = 4'b1000
  } aluc_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [4:0] JAL_RN = 5'd31;

endpackage

// File: rtl/pipe_exe_if.sv
// ID -> EX bundle: decoded controls/operands in, EX controls and results back out.
interface pipe_exe_if #(parameter int unsigned WIDTH = 32);
  logic             dwreg, dm2reg, dwmem, djal, dshift, daluimm;
  logic [3:0]       daluc;
  logic [WIDTH-1:0] da, db, dimm, dpc4;
  logic [4:0]       drn;
  logic             ewreg, em2reg, ewmem;
  logic [4:0]       ern;
  logic [WIDTH-1:0] ealu, eb;
  logic             exe_busy;

  modport master (
    output dwreg, dm2reg, dwmem, djal, dshift, daluimm, daluc, da, db, dimm, dpc4, drn,
    input  ewreg, em2reg, ewmem, ern, ealu, eb, exe_busy
  );

  modport slave (
    input  dwreg, dm2reg, dwmem, djal, dshift, daluimm, daluc, da, db, dimm, dpc4, drn,
    output ewreg, em2reg, ewmem, ern, ealu, eb, exe_busy
  );
endinterface

// File: rtl/pipe_muldiv.sv
// Iterative radix-2 signed multiply (shift-add) / divide (restoring), one bit per cycle.
module pipe_muldiv
  import pipe_exe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int unsigned CW = $clog2(WIDTH);

  md_state_e        state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] acc, acc_n, x, x_n, y, y_n, quot;
  logic             neg, neg_n, is_div, is_div_n;
  logic [WIDTH:0]   r2;
  logic             fits;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= MD_IDLE;
      count  <= '0;
      acc    <= '0;
      x      <= '0;
      y      <= '0;
      neg    <= 1'b0;
      is_div <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      acc    <= acc_n;
      x      <= x_n;
      y      <= y_n;
      neg    <= neg_n;
      is_div <= is_div_n;
    end
  end

  // acc: product / partial remainder; x: multiplicand / divisor; y: multiplier / dividend->quotient
  always_comb begin
    state_n  = state;
    count_n  = count;
    acc_n    = acc;
    x_n      = x;
    y_n      = y;
    neg_n    = neg;
    is_div_n = is_div;
    r2       = {acc, y[WIDTH-1]};
    fits     = r2 >= {1'b0, x};
    unique case (state)
      MD_IDLE: begin
        if (start) begin
          state_n  = MD_RUN;
          count_n  = CW'(WIDTH - 1);
          acc_n    = '0;
          x_n      = b[WIDTH-1] ? -b : b;
          y_n      = a[WIDTH-1] ? -a : a;
          neg_n    = a[WIDTH-1] ^ b[WIDTH-1];
          is_div_n = op_div;
        end
      end
      MD_RUN: begin
        if (is_div) begin
          acc_n = fits ? (r2[WIDTH-1:0] - x) : r2[WIDTH-1:0];
          y_n   = {y[WIDTH-2:0], fits};
        end else begin
          if (y[0]) acc_n = acc + x;
          x_n = x << 1;
          y_n = y >> 1;
        end
        if (count == '0) state_n = MD_DONE;
        else             count_n = count - 1'b1;
      end
      MD_DONE: state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  assign busy = start && (state != MD_DONE);
  assign done = (state == MD_DONE);
  assign quot = is_div ? y : acc;

  // A zero divisor yields all-ones regardless of the dividend's sign.
  always_comb begin
    if (is_div && x == '0) result = '1;
    else                   result = neg ? -quot : quot;
  end
endmodule

// File: rtl/pipe_exe_stage.sv
// ID/EX pipeline register plus execute stage with iterative signed mul/div.
// MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module pipe_exe_stage
  import pipe_exe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clock,
  input  logic        resetn,
  pipe_exe_if.slave   ex
);
  logic             wreg_q, m2reg_q, wmem_q, jal_q, shift_q, aluimm_q;
  logic [3:0]       aluc_q;
  logic [WIDTH-1:0] a_q, b_q, imm_q, pc4_q;
  logic [4:0]       rn_q;

  logic             md_op, md_div, md_busy, md_done, ctrl_open;
  logic [WIDTH-1:0] opa, opb, alu, md_result;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wreg_q   <= 1'b0;
      m2reg_q  <= 1'b0;
      wmem_q   <= 1'b0;
      jal_q    <= 1'b0;
      shift_q  <= 1'b0;
      aluimm_q <= 1'b0;
      aluc_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      rn_q     <= '0;
    end else if (!md_busy) begin
      wreg_q   <= ex.dwreg;
      m2reg_q  <= ex.dm2reg;
      wmem_q   <= ex.dwmem;
      jal_q    <= ex.djal;
      shift_q  <= ex.dshift;
      aluimm_q <= ex.daluimm;
      aluc_q   <= ex.daluc;
      a_q      <= ex.da;
      b_q      <= ex.db;
      imm_q    <= ex.dimm;
      pc4_q    <= ex.dpc4;
      rn_q     <= ex.drn;
    end
  end

  assign opa    = shift_q ? WIDTH'(imm_q[10:6]) : a_q;
  assign opb    = aluimm_q ? imm_q : b_q;
  assign md_div = (aluc_q == ALUC_DIV);
`ifdef MULDIV_FAST_MUL_EN
  assign md_op  = md_div;
`else
  assign md_op  = md_div || (aluc_q == ALUC_MUL);
`endif

  pipe_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock  (clock),
    .resetn (resetn),
    .start  (md_op),
    .op_div (md_div),
    .a      (opa),
    .b      (opb),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    alu = '0;
    case (aluc_q)
      ALUC_ADD: alu = opa + opb;
      ALUC_SUB: alu = opa - opb;
      ALUC_AND: alu = opa & opb;
      ALUC_OR:  alu = opa | opb;
      ALUC_XOR: alu = opa ^ opb;
      ALUC_LUI: alu = opb << 16;
      ALUC_SLL: alu = opb << opa[4:0];
      ALUC_SRL: alu = opb >> opa[4:0];
      ALUC_SRA: alu = $signed(opb) >>> opa[4:0];
`ifdef MULDIV_FAST_MUL_EN
      ALUC_MUL: alu = opa * opb;
`else
      ALUC_MUL: alu = md_result;
`endif
      ALUC_DIV: alu = md_result;
      default:  alu = '0;
    endcase
  end

  // Write/store controls pass through only once the mul/div result is final.
  assign ctrl_open   = !md_op || md_done;
  assign ex.ewreg    = wreg_q & ctrl_open;
  assign ex.ewmem    = wmem_q & ctrl_open;
  assign ex.em2reg   = m2reg_q;
  assign ex.ern      = jal_q ? JAL_RN : rn_q;
  assign ex.ealu     = jal_q ? (pc4_q + WIDTH'(4)) : alu;
  assign ex.eb       = b_q;
  assign ex.exe_busy = md_busy;
endmodule
